// File: rtl/seg_arb_pkg.sv
// Shared types and elaboration helpers for the segment-select arbiter.
// Holds the FSM state encoding, a log2 helper and the configuration sanity check.
package seg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int SEL_W_DEFAULT    = 3;
  localparam int N_SEG_DEFAULT    = 4;
  localparam int HOLD_MAX_DEFAULT = 16;

  // Smallest r with 2**r >= value; sizes the hold counter.
  function automatic int clog2_f(input int value);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= value) return r;
    end
    return 31;
  endfunction

  function automatic bit sel_fits(input int n_seg, input int sel_w);
    return n_seg <= (1 << sel_w);
  endfunction

  localparam bit DEFAULT_CFG_OK = sel_fits(N_SEG_DEFAULT, SEL_W_DEFAULT);

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set bit of eff at or above ptr, wrapping at N_SEG.
// Purely combinational; ptr is assumed to be below N_SEG.
module rr_pick
  import seg_arb_pkg::*;
#(
  parameter int N_SEG = N_SEG_DEFAULT,
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic [N_SEG-1:0] eff,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] index
);

  logic [2*N_SEG-1:0] doubled;
  logic [N_SEG-1:0]   rotated;
  logic [SEL_W-1:0]   offset;
  logic [SEL_W:0]     sum;

  // Rotate so ptr lands on bit 0, find the lowest set bit, then rotate the index back.
  always_comb begin
    doubled = {eff, eff};
    rotated = N_SEG'(doubled >> ptr);
    found   = |rotated;
    offset  = '0;
    for (int i = N_SEG - 1; i >= 0; i--) begin
      if (rotated[i]) offset = SEL_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (SEL_W + 1)'(N_SEG)) sum = sum - (SEL_W + 1)'(N_SEG);
    index = sum[SEL_W-1:0];
  end

endmodule

// File: rtl/seg_sel_arbiter.sv
// Round-robin owner of the shared segment-select decoder, with break-before-make gap,
// hold-time limit and a security mask that blocks requesters from the scan path.
module seg_sel_arbiter
  import seg_arb_pkg::*;
#(
  parameter int SEL_W    = SEL_W_DEFAULT,
  parameter int N_SEG    = N_SEG_DEFAULT,
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SEG-1:0] req,
  input  logic             mask_wr,
  input  logic [N_SEG-1:0] mask_in,
  output logic [N_SEG-1:0] grant,
  output logic [SEL_W-1:0] sel_code,
  output logic             sel_valid,
  output logic             timeout
);

  localparam int  CNT_W  = clog2_f(HOLD_MAX + 1);
  localparam bit  cfg_ok = sel_fits(N_SEG, SEL_W) && (HOLD_MAX >= 1) && DEFAULT_CFG_OK;

  if (!cfg_ok) begin : g_cfg_err
    $error("seg_sel_arbiter: need N_SEG <= 2**SEL_W and HOLD_MAX >= 1");
  end

  arb_state_e       state_q, state_d;
  logic [N_SEG-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_code_q, sel_code_d;
  logic             sel_valid_q, sel_valid_d;
  logic             timeout_q, timeout_d;
  logic [N_SEG-1:0] mask_q, mask_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [N_SEG-1:0] eff;
  logic             pick_found;
  logic [SEL_W-1:0] pick_index;
  logic             owner_ok;

  assign eff = req & ~mask_q;

  rr_pick #(
    .N_SEG (N_SEG),
    .SEL_W (SEL_W)
  ) u_rr_pick (
    .eff   (eff),
    .ptr   (ptr_q),
    .found (pick_found),
    .index (pick_index)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_code_d  = sel_code_q;
    sel_valid_d = sel_valid_q;
    timeout_d   = 1'b0;
    mask_d      = mask_wr ? mask_in : mask_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;

    // Grant is one-hot, so this picks out the owner's own request/mask bits.
    owner_ok = 1'b0;
    for (int i = 0; i < N_SEG; i++) begin
      if (grant_q[i]) owner_ok = req[i] & ~mask_q[i];
    end

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d     = N_SEG'(1) << pick_index;
          sel_code_d  = pick_index;
          sel_valid_d = 1'b1;
          hold_d      = CNT_W'(1);
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!owner_ok || hold_q == CNT_W'(HOLD_MAX)) begin
          // A voluntary drop or mask hit wins over the hold limit: no timeout then.
          timeout_d   = owner_ok;
          grant_d     = '0;
          sel_valid_d = 1'b0;
          hold_d      = '0;
          ptr_d       = (sel_code_q == SEL_W'(N_SEG - 1)) ? '0 : sel_code_q + SEL_W'(1);
          state_d     = GAP;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        sel_valid_d = 1'b0;
        hold_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sel_code_q  <= '0;
      sel_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      mask_q      <= '0;
      ptr_q       <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_code_q  <= sel_code_d;
      sel_valid_q <= sel_valid_d;
      timeout_q   <= timeout_d;
      mask_q      <= mask_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign grant     = grant_q;
  assign sel_code  = sel_code_q;
  assign sel_valid = sel_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_seg_sel_arbiter.sv
// Directed bench for seg_sel_arbiter: a round-robin vector table followed by
// hand-written timeout, mask, wrap-around and asynchronous-reset sequences.
module tb_seg_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       mask_wr;
  logic [3:0] mask_in;
  logic [3:0] grant;
  logic [2:0] sel_code;
  logic       sel_valid;
  logic       timeout;

  int total;
  int bad;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       mask_wr;
    logic [3:0] mask_in;
    logic [3:0] exp_grant;
    logic       exp_valid;
    logic [2:0] exp_code;
    logic       exp_timeout;
  } vec_t;

  vec_t vecs [25];

  seg_sel_arbiter #(
    .SEL_W    (3),
    .N_SEG    (4),
    .HOLD_MAX (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mask_wr   (mask_wr),
    .mask_in   (mask_in),
    .grant     (grant),
    .sel_code  (sel_code),
    .sel_valid (sel_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs, advance one rising edge, and leave time 1 unit past it for sampling.
  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic mw,
                               input logic [3:0] mi);
    rst_n   = r;
    req     = rq;
    mask_wr = mw;
    mask_in = mi;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input logic [7:0] actual, input logic [7:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] g, input logic v,
                             input logic [2:0] c, input logic to);
    cmp({name, ".grant"},     {4'h0, grant},     {4'h0, g});
    cmp({name, ".sel_valid"}, {7'h0, sel_valid}, {7'h0, v});
    cmp({name, ".sel_code"},  {5'h0, sel_code},  {5'h0, c});
    cmp({name, ".timeout"},   {7'h0, timeout},   {7'h0, to});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    req     = 4'b1111;
    mask_wr = 1'b0;
    mask_in = 4'b0000;

    // Reset, then round-robin 0,1,2,3,0 with each owner dropping after 3 grant cycles.
    vecs[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b1, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b1, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b1, 3'd0, 1'b0};
    vecs[4]  = '{1'b1, 4'b1110, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
    vecs[5]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
    vecs[6]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0010, 1'b1, 3'd1, 1'b0};
    vecs[7]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0010, 1'b1, 3'd1, 1'b0};
    vecs[8]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0010, 1'b1, 3'd1, 1'b0};
    vecs[9]  = '{1'b1, 4'b1101, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd1, 1'b0};
    vecs[10] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd1, 1'b0};
    vecs[11] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b1, 3'd2, 1'b0};
    vecs[12] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b1, 3'd2, 1'b0};
    vecs[13] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b1, 3'd2, 1'b0};
    vecs[14] = '{1'b1, 4'b1011, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd2, 1'b0};
    vecs[15] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd2, 1'b0};
    vecs[16] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b1, 3'd3, 1'b0};
    vecs[17] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b1, 3'd3, 1'b0};
    vecs[18] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b1, 3'd3, 1'b0};
    vecs[19] = '{1'b1, 4'b0111, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd3, 1'b0};
    vecs[20] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd3, 1'b0};
    vecs[21] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 4'b0001, 1'b1, 3'd0, 1'b0};
    vecs[22] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
    vecs[23] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};
    vecs[24] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0, 1'b0};

    #2;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].rst_n, vecs[i].req, vecs[i].mask_wr, vecs[i].mask_in);
      checkOutput($sformatf("rr[%0d]", i), vecs[i].exp_grant, vecs[i].exp_valid,
                  vecs[i].exp_code, vecs[i].exp_timeout);
    end

    // Hold limit: requester 2 alone keeps grant for exactly 16 cycles, then is revoked.
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0000);
      checkOutput($sformatf("hold[%0d]", k), 4'b0100, 1'b1, 3'd2, 1'b0);
    end
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0000);
    checkOutput("to_release", 4'b0000, 1'b0, 3'd2, 1'b1);
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0000);
    checkOutput("to_gap", 4'b0000, 1'b0, 3'd2, 1'b0);
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0000);
    checkOutput("to_regrant", 4'b0100, 1'b1, 3'd2, 1'b0);

    // Owner 2 drops; pointer 3 wraps to requester 1, which is then masked off.
    applyStimulus(1'b1, 4'b0010, 1'b0, 4'b0000);
    checkOutput("m_drop", 4'b0000, 1'b0, 3'd2, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b0, 4'b0000);
    checkOutput("m_gap", 4'b0000, 1'b0, 3'd2, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b0, 4'b0000);
    checkOutput("m_grant1", 4'b0010, 1'b1, 3'd1, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b1, 4'b0010);
    checkOutput("m_write", 4'b0010, 1'b1, 3'd1, 1'b0);
    applyStimulus(1'b1, 4'b0010, 1'b0, 4'b0000);
    checkOutput("m_revoke", 4'b0000, 1'b0, 3'd1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1, 4'b0010, 1'b0, 4'b0000);
      checkOutput($sformatf("m_blocked[%0d]", k), 4'b0000, 1'b0, 3'd1, 1'b0);
    end

    // Clear the mask, serve 2, then 0 wins from pointer 3, then 2 again from pointer 1.
    applyStimulus(1'b1, 4'b0100, 1'b1, 4'b0000);
    checkOutput("w_grant2", 4'b0100, 1'b1, 3'd2, 1'b0);
    applyStimulus(1'b1, 4'b0001, 1'b0, 4'b0000);
    checkOutput("w_drop2", 4'b0000, 1'b0, 3'd2, 1'b0);
    applyStimulus(1'b1, 4'b0101, 1'b0, 4'b0000);
    checkOutput("w_gap", 4'b0000, 1'b0, 3'd2, 1'b0);
    applyStimulus(1'b1, 4'b0101, 1'b0, 4'b0000);
    checkOutput("w_wrap0", 4'b0001, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0000);
    checkOutput("w_drop0", 4'b0000, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0000);
    checkOutput("w_gap2", 4'b0000, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 4'b0100, 1'b0, 4'b0000);
    checkOutput("w_grant2b", 4'b0100, 1'b1, 3'd2, 1'b0);

    // Asynchronous reset between edges clears outputs immediately; regrant needs no gap.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("ar_async", 4'b0000, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 4'b0000);
    checkOutput("ar_regrant", 4'b0001, 1'b1, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_sel_arbiter.md
Name: seg_sel_arbiter

Overview:
- Round-robin arbiter that shares one segment-select decoder between N_SEG requesters in the Secure-IJTAG network.
- Emits a binary select code plus a valid strobe; the external decoder (SEL_W in, N_SEG out) turns the code into one-hot segment enables.
- Enforces break-before-make with a one-cycle gap between grants.
- Enforces a maximum hold time and a security mask, so a locked or hung requester cannot own the scan path.

Parameters:
- SEL_W, 3, width of the binary select code driven to the decoder.
- N_SEG, 4, number of requesters/segments; must satisfy N_SEG <= 2**SEL_W.
- HOLD_MAX, 16, maximum consecutive GRANT cycles before forced release; must be >= 1.

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_SEG  per-requester request, level-sensitive.
- mask_wr  input  1  load strobe for the security mask.
- mask_in  input  N_SEG  new mask value; bit=1 means requester blocked.
- grant  output  N_SEG  one-hot grant to requesters (zero when idle).
- sel_code  output  SEL_W  binary index of the granted segment, to the decoder input.
- sel_valid  output  1  high while sel_code is driving a live selection.
- timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX.

Behaviour:
- Reset (async assert, sync release):
  - grant=0, sel_code=0, sel_valid=0, timeout=0.
  - mask=0 (all allowed); rr pointer=0 (requester 0 has highest priority); state=IDLE; hold counter=0.
- Effective request: eff = req & ~mask.
- State IDLE:
  - If eff != 0, pick the first set bit of eff searching upward from the rr pointer, wrapping at N_SEG.
  - Register grant, sel_code and sel_valid=1 on the same edge; go to GRANT with hold counter=1.
  - Latency: req rise to grant high is 1 cycle.
- State GRANT:
  - Each cycle, release if the granted requester drops req or becomes masked.
  - Otherwise release if hold counter == HOLD_MAX; in that case pulse timeout for 1 cycle.
  - Otherwise increment the hold counter.
  - On release, on the same edge: grant=0, sel_valid=0, rr pointer = granted index + 1 (mod N_SEG); go to GAP.
- State GAP:
  - Exactly 1 cycle with grant=0 and sel_valid=0 (break-before-make); then go to IDLE.
  - No new grant is made in GAP.
  - Minimum spacing between two grants is therefore 2 idle cycles at the outputs.
- sel_code:
  - Holds its last value while sel_valid=0; this is don't-care to downstream logic.
  - Never exceeds N_SEG-1.
- Mask writes:
  - mask_wr loads mask on the next edge; the new mask takes effect from that edge.
  - A write that masks the current owner forces release in the following cycle. This does not raise timeout.
- Simultaneous events:
  - Timeout and owner req drop on the same cycle: treated as a normal release, timeout=0.
  - Requests arriving during GRANT or GAP are evaluated only in IDLE.
- Reset mid-grant: all outputs drop to 0 asynchronously; no gap cycle is required after reset.
- Invariant: grant is zero or one-hot, and when sel_valid=1, grant[sel_code]=1.

Decomposition:
- Package seg_arb_pkg:
  - state enum {IDLE, GRANT, GAP};
  - log2 helper for the hold-counter width;
  - a compile-time assertion constant checking N_SEG <= 2**SEL_W.
- Sub-module rr_pick:
  - Combinational rotate-priority-encoder.
  - Inputs: eff, pointer. Outputs: found, index.
- The arbiter FSM, counter and registers live in seg_sel_arbiter.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 → grant=0, sel_valid=0; release reset, next edge → grant=4'b0001, sel_code=0.
- Round-robin: req=4'b1111 held constantly, each requester drops req after 3 grant cycles → grant order 0,1,2,3,0 with a 1-cycle gap between each.
- Timeout: req=4'b0100 held forever, HOLD_MAX=16 → grant=4'b0100 for 16 cycles, timeout pulses once, gap, then re-grant index 2.
- Mask: grant active on index 1, write mask=4'b0010 → next cycle grant=0, timeout=0; later req=4'b0010 alone → never granted.
- Wrap and skip: pointer=3 after serving index 2, req=4'b0101 → index 0 granted (wraps past 3), then index 2.
- Async reset mid-grant: assert rst_n low mid-cycle while granted → grant and sel_valid drop immediately, before the next clk edge.
